// File: rtl/dsa_spi_pkg.sv
// Shared types and defaults for the DSA serial bus arbiter.
// The same pointer/grant conventions are reused by the AGC panel scheduler.
package dsa_spi_pkg;

    localparam int DSA_WORD_W   = 16;
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;

    // Shared phase timer; wide enough for any practical setup, hold or half-period.
    localparam int TIMER_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

endpackage

// File: rtl/dsa_spi_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request at or after
// i_ptr (wrapping) wins, returned both one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    logic [2*NUM_CH-1:0] w_dbl;
    logic [NUM_CH-1:0]   w_rot;
    logic [IDX_W-1:0]    w_off;
    logic [IDX_W:0]      w_sum;

    // Rotating the doubled vector puts the pointer's channel at bit 0.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NUM_CH-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= (IDX_W+1)'(NUM_CH)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_CH))
                                                   : w_sum[IDX_W-1:0];
    assign o_any   = |i_req;
    assign o_grant = o_any ? (NUM_CH'(1) << o_idx) : '0;

endmodule

// File: rtl/dsa_spi_arbiter.sv
// Shares one DSA serial bus among NUM_CH attenuator writers: round-robin grant,
// one MSB-first mode-0 SPI word per grant, then a one-cycle done pulse.
module dsa_spi_arbiter
    import dsa_spi_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DATA_W   = DSA_WORD_W,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [NUM_CH-1:0]        req_done,
    output logic                     busy,
    output logic                     spi_clk,
    output logic                     spi_mosi,
    output logic [NUM_CH-1:0]        spi_cs_n
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    spi_state_t          r_state;
    logic [TIMER_W-1:0]  r_tmr;
    logic [BIT_W-1:0]    r_bit;
    logic [DATA_W-1:0]   r_shift;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_CH-1:0]   r_cs_n;
    logic                r_sclk;
    logic                r_busy;
    logic [NUM_CH-1:0]   r_done;

    spi_state_t          w_state_nxt;
    logic [TIMER_W-1:0]  w_tmr_nxt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [IDX_W-1:0]    w_grant_nxt;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [NUM_CH-1:0]   w_cs_n_nxt;
    logic                w_sclk_nxt;
    logic                w_busy_nxt;
    logic [NUM_CH-1:0]   w_done_nxt;
    logic [NUM_CH-1:0]   w_ready;

    logic [NUM_CH-1:0]   w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_any;
    logic [DATA_W-1:0]   w_word;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    always_comb begin
        w_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_arb_grant[c]) begin
                w_word = req_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cs_n_nxt  = r_cs_n;
        w_sclk_nxt  = r_sclk;
        w_busy_nxt  = r_busy;
        w_done_nxt  = '0;
        w_ready     = '0;

        case (r_state)
            ST_IDLE: begin
                if (en && w_arb_any) begin
                    w_ready     = w_arb_grant;
                    w_shift_nxt = w_word;
                    w_cs_n_nxt  = ~w_arb_grant;
                    w_grant_nxt = w_arb_idx;
                    w_tmr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (r_tmr == TIMER_W'(CS_SETUP - 1)) begin
                    w_tmr_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end

            // Timer spans one bit: low half then high half; the word advances on the fall.
            ST_SHIFT: begin
                if (r_tmr == TIMER_W'(2*CLK_DIV - 1)) begin
                    w_sclk_nxt = 1'b0;
                    w_tmr_nxt  = '0;
                    if (r_bit == BIT_W'(DATA_W - 1)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_shift_nxt = r_shift << 1;
                        w_bit_nxt   = r_bit + 1'b1;
                    end
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                    if (r_tmr == TIMER_W'(CLK_DIV - 1)) begin
                        w_sclk_nxt = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (r_tmr == TIMER_W'(CS_HOLD - 1)) begin
                    w_cs_n_nxt  = '1;
                    w_done_nxt  = NUM_CH'(1) << r_grant;
                    w_ptr_nxt   = (r_grant == IDX_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end

            ST_GAP: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset aborts any transfer on the spot: bus released, no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cs_n  <= '1;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_sclk  <= w_sclk_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign req_ready = rst ? '0 : w_ready;
    assign req_done  = r_done;
    assign busy      = r_busy;
    assign spi_clk   = r_sclk;
    assign spi_mosi  = r_shift[DATA_W-1];
    assign spi_cs_n  = r_cs_n;

endmodule

// File: tb/tb_dsa_spi_arbiter.sv
// Bench for dsa_spi_arbiter: a timeline model of each grant checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_dsa_spi_arbiter;

    localparam int NCH   = 4;
    localparam int W     = 16;
    localparam int D     = 4;
    localparam int SU    = 2;
    localparam int HO    = 2;
    localparam int CSLOW = SU + 2*D*W + HO;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [NCH-1:0]   reqValid;
    logic [NCH*W-1:0] reqData;
    logic [NCH-1:0]   reqReady;
    logic [NCH-1:0]   reqDone;
    logic             busy;
    logic             spiClk;
    logic             spiMosi;
    logic [NCH-1:0]   spiCsN;

    logic [NCH-1:0]   fValid;
    logic [NCH*W-1:0] fData;
    logic [NCH-1:0]   fReady;
    logic [NCH-1:0]   fDone;
    logic             fBusy;
    logic             fSclk;
    logic             fMosi;
    logic [NCH-1:0]   fCsN;

    int total = 0;
    int bad   = 0;

    int negCyc = 0;
    logic [NCH-1:0] hsMask = '0;
    int grantIdx[$];
    int grantCyc[$];
    int doneIdx[$];
    int doneCyc[$];
    int csLowCnt[NCH];
    int readyCnt;
    int busyCnt;
    logic [W-1:0] shiftIn[NCH];
    int bitCnt[NCH];
    logic [W-1:0] rxWord[NCH];
    int rxBits[NCH];
    logic [NCH-1:0] prevCs = '1;
    logic prevSclk = 1'b0;

    bit mActive = 1'b0;
    int mK = 0;
    int mG = 0;
    int mPtr = 0;
    logic [W-1:0] mWord = '0;

    int fCyc = 0;
    logic [NCH-1:0] fHs = '0;
    int fGrantCyc = -1;
    int fDoneCyc = -1;
    int fCsLow = 0;
    int fRises = 0;
    int fLastRise = -1;
    int fBadGap = 0;
    logic [W-1:0] fRx = '0;
    logic fPrevSclk = 1'b0;

    always #5 clk = ~clk;

    dsa_spi_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (reqValid),
        .req_data  (reqData),
        .req_ready (reqReady),
        .req_done  (reqDone),
        .busy      (busy),
        .spi_clk   (spiClk),
        .spi_mosi  (spiMosi),
        .spi_cs_n  (spiCsN)
    );

    dsa_spi_arbiter #(
        .NUM_CH   (NCH),
        .DATA_W   (W),
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1)
    ) dutFast (
        .clk       (clk),
        .rst       (rst),
        .en        (1'b1),
        .req_valid (fValid),
        .req_data  (fData),
        .req_ready (fReady),
        .req_done  (fDone),
        .busy      (fBusy),
        .spi_clk   (fSclk),
        .spi_mosi  (fMosi),
        .spi_cs_n  (fCsN)
    );

    function automatic logic [NCH-1:0] onehot(input int i);
        logic [NCH-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int firstFrom(input logic [NCH-1:0] v, input int p);
        for (int o = 0; o < NCH; o++) begin
            if (v[(p + o) % NCH]) return (p + o) % NCH;
        end
        return -1;
    endfunction

    function automatic int idxOf(input logic [NCH-1:0] v);
        for (int c = 0; c < NCH; c++) begin
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, negCyc);
        end
    endtask

    // Reference: per-grant timeline from the timing rules, arbitration by pointer search.
    initial forever begin : cmpProc
        logic [NCH-1:0] eCs, eDone, eReady;
        logic eSclk, eMosi, eBusy;
        bit mosiValid;
        int s;
        @(negedge clk);
        negCyc++;
        eCs = '1; eDone = '0; eReady = '0;
        eSclk = 1'b0; eMosi = 1'b0; eBusy = 1'b0; mosiValid = 1'b0;

        hsMask = reqReady & reqValid;
        if (hsMask != '0) begin
            grantIdx.push_back(idxOf(hsMask));
            grantCyc.push_back(negCyc);
        end
        if (reqDone != '0) begin
            doneIdx.push_back(idxOf(reqDone));
            doneCyc.push_back(negCyc);
        end
        if (reqReady != '0) readyCnt++;
        if (busy === 1'b1) busyCnt++;
        for (int c = 0; c < NCH; c++) begin
            if (spiCsN[c] === 1'b0) begin
                csLowCnt[c]++;
                if (prevCs[c] === 1'b1) begin
                    shiftIn[c] = '0;
                    bitCnt[c] = 0;
                end
                if (spiClk && !prevSclk) begin
                    shiftIn[c] = {shiftIn[c][W-2:0], spiMosi};
                    bitCnt[c]++;
                end
            end else if (prevCs[c] === 1'b0) begin
                rxWord[c] = shiftIn[c];
                rxBits[c] = bitCnt[c];
            end
        end
        prevCs = spiCsN;
        prevSclk = spiClk;

        if (rst) begin
            mosiValid = 1'b1;
            mActive = 1'b0;
            mPtr = 0;
        end else if (!mActive) begin
            if (en && (reqValid != '0)) begin
                mG = firstFrom(reqValid, mPtr);
                eReady = onehot(mG);
                mWord = reqData[mG*W +: W];
                mActive = 1'b1;
                mK = 0;
            end
        end else begin
            mK++;
            eBusy = 1'b1;
            mosiValid = 1'b1;
            eCs = (mK <= CSLOW) ? ~onehot(mG) : '1;
            eDone = (mK == CSLOW + 1) ? onehot(mG) : '0;
            s = mK - 1 - SU;
            if (mK <= SU) begin
                eMosi = mWord[W-1];
            end else if (s < 2*D*W) begin
                eSclk = ((s % (2*D)) >= D);
                eMosi = mWord[W-1 - s/(2*D)];
            end else begin
                eMosi = mWord[0];
            end
            if (mK == CSLOW + 1) begin
                mActive = 1'b0;
                mPtr = (mG + 1) % NCH;
            end
        end

        checkOutput("req_ready", reqReady, eReady);
        checkOutput("spi_cs_n", spiCsN, eCs);
        checkOutput("spi_clk", spiClk, eSclk);
        checkOutput("busy", busy, eBusy);
        checkOutput("req_done", reqDone, eDone);
        checkOutput("one_cs_low", ($countones(~spiCsN) <= 1), 1);
        if (mosiValid) checkOutput("spi_mosi", spiMosi, eMosi);
    end

    initial forever begin : fastMon
        @(negedge clk);
        fCyc++;
        fHs = fReady & fValid;
        if (fHs != '0) fGrantCyc = fCyc;
        if (fDone != '0) fDoneCyc = fCyc;
        if (fCsN[1] === 1'b0) begin
            fCsLow++;
            if (fSclk && !fPrevSclk) begin
                fRx = {fRx[W-2:0], fMosi};
                fRises++;
                if (fLastRise >= 0 && (fCyc - fLastRise) != 2) fBadGap++;
                fLastRise = fCyc;
            end
        end
        fPrevSclk = fSclk;
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
        reqValid = reqValid & ~hsMask;
        fValid = fValid & ~fHs;
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH*W-1:0] d);
        for (int c = 0; c < NCH; c++) begin
            if (v[c]) reqData[c*W +: W] = d[c*W +: W];
        end
        reqValid = reqValid | v;
    endtask

    task automatic clearLogs();
        grantIdx.delete(); grantCyc.delete();
        doneIdx.delete(); doneCyc.delete();
        readyCnt = 0; busyCnt = 0;
        for (int c = 0; c < NCH; c++) csLowCnt[c] = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        reqValid = '0;
        runCycles(2);
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic waitGrants(input int n, input int budget, input string name);
        int k = 0;
        while (grantIdx.size() < n && k < budget) begin
            stepCycle();
            k++;
        end
        if (grantIdx.size() < n) begin
            total++; bad++;
            $display("[TB] FAIL %s: timeout with %0d grants, required %0d", name, grantIdx.size(), n);
        end
    endtask

    task automatic waitDones(input int n, input int budget, input string name);
        int k = 0;
        while (doneIdx.size() < n && k < budget) begin
            stepCycle();
            k++;
        end
        if (doneIdx.size() < n) begin
            total++; bad++;
            $display("[TB] FAIL %s: timeout with %0d dones, required %0d", name, doneIdx.size(), n);
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b1;
        reqValid = '0;
        reqData = '0;
        fValid = '0;
        fData = '0;
        for (int c = 0; c < NCH; c++) begin
            shiftIn[c] = '0; bitCnt[c] = 0; rxWord[c] = '0; rxBits[c] = 0; csLowCnt[c] = 0;
        end
        #1 rst = 1'b1;
        reqValid = 4'hF;
        runCycles(3);
        checkOutput("rst_ready", reqReady, 4'h0);
        checkOutput("rst_cs_n", spiCsN, 4'hF);
        checkOutput("rst_sclk", spiClk, 1'b0);
        checkOutput("rst_mosi", spiMosi, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", reqDone, 4'h0);
        reqValid = '0;
        rst = 1'b0;

        $display("[TB] single request ch0");
        doReset();
        applyStimulus(4'b0001, 64'h0000_0000_0000_A5C3);
        waitGrants(1, 20, "single_grant");
        waitDones(1, 200, "single_done");
        runCycles(2);
        checkOutput("single_idx", grantIdx[0], 0);
        checkOutput("single_ready_width", readyCnt, 1);
        checkOutput("single_cs_low", csLowCnt[0], 132);
        checkOutput("single_latency", doneCyc[0] - grantCyc[0], 133);
        checkOutput("single_done_idx", doneIdx[0], 0);
        checkOutput("single_word", rxWord[0], 16'hA5C3);
        checkOutput("single_bits", rxBits[0], 16);

        $display("[TB] four simultaneous requests");
        doReset();
        applyStimulus(4'hF, 64'h0008_0004_0002_0001);
        waitGrants(4, 600, "four_grants");
        waitDones(4, 200, "four_dones");
        for (int i = 0; i < NCH; i++) begin
            checkOutput("four_order", grantIdx[i], i);
            checkOutput("four_word", rxWord[i], 16'(1 << i));
            if (i > 0) checkOutput("four_spacing", grantCyc[i] - grantCyc[i-1], 134);
        end

        $display("[TB] fairness after serving ch1");
        doReset();
        applyStimulus(4'b0010, 64'h0000_0000_1234_0000);
        waitDones(1, 200, "fair_first");
        applyStimulus(4'b0011, 64'h0000_0000_4321_8765);
        waitDones(3, 400, "fair_rest");
        checkOutput("fair_g0", grantIdx[0], 1);
        checkOutput("fair_g1", grantIdx[1], 0);
        checkOutput("fair_g2", grantIdx[2], 1);
        checkOutput("fair_word0", rxWord[0], 16'h8765);
        checkOutput("fair_word1", rxWord[1], 16'h4321);

        $display("[TB] enable gating");
        runCycles(3);
        en = 1'b0;
        applyStimulus(4'b0100, 64'h0000_5A5A_0000_0000);
        clearLogs();
        runCycles(50);
        checkOutput("en_low_ready", readyCnt, 0);
        checkOutput("en_low_busy", busyCnt, 0);
        en = 1'b1;
        stepCycle();
        checkOutput("en_grant_now", grantIdx.size(), 1);
        checkOutput("en_grant_idx", grantIdx[0], 2);
        runCycles(40);
        en = 1'b0;
        applyStimulus(4'b1000, 64'h3C96_0000_0000_0000);
        waitDones(1, 200, "en_mid_done");
        checkOutput("en_mid_done_idx", doneIdx[0], 2);
        checkOutput("en_mid_word", rxWord[2], 16'h5A5A);
        runCycles(10);
        checkOutput("en_low_no_grant", grantIdx.size(), 1);
        en = 1'b1;
        waitGrants(2, 5, "en_raise_grant");
        checkOutput("en_raise_idx", grantIdx[1], 3);

        $display("[TB] reset during shift");
        runCycles(60);
        rst = 1'b1;
        #1;
        checkOutput("abort_cs_n", spiCsN, 4'hF);
        checkOutput("abort_sclk", spiClk, 1'b0);
        checkOutput("abort_mosi", spiMosi, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ready", reqReady, 4'h0);
        clearLogs();
        runCycles(2);
        rst = 1'b0;
        applyStimulus(4'b1000, 64'hC0DE_0000_0000_0000);
        waitGrants(1, 20, "post_rst_grant");
        waitDones(1, 200, "post_rst_done");
        runCycles(2);
        checkOutput("post_rst_idx", grantIdx[0], 3);
        checkOutput("post_rst_done_count", doneIdx.size(), 1);
        checkOutput("post_rst_latency", doneCyc[0] - grantCyc[0], 133);
        checkOutput("post_rst_word", rxWord[3], 16'hC0DE);
        checkOutput("post_rst_bits", rxBits[3], 16);

        $display("[TB] random traffic");
        doReset();
        for (int t = 0; t < 4000; t++) begin
            stepCycle();
            en = ($urandom_range(0, 15) != 0);
            for (int c = 0; c < NCH; c++) begin
                if (!reqValid[c]) begin
                    reqData[c*W +: W] = W'($urandom);
                    if ($urandom_range(0, 59) == 0) reqValid[c] = 1'b1;
                end else if ($urandom_range(0, 499) == 0) begin
                    reqValid[c] = 1'b0;
                end
            end
        end
        reqValid = '0;
        en = 1'b1;
        for (int k = 0; k < 200 && busy; k++) stepCycle();
        checkOutput("random_idle", busy, 1'b0);
        checkOutput("random_activity", (grantIdx.size() >= 10), 1);

        $display("[TB] fast timing instance");
        fCsLow = 0; fRises = 0; fLastRise = -1; fBadGap = 0; fGrantCyc = -1; fDoneCyc = -1;
        fData[31:16] = 16'h9E37;
        fValid = 4'b0010;
        for (int k = 0; k < 100 && fDoneCyc < 0; k++) stepCycle();
        runCycles(2);
        checkOutput("fast_cs_low", fCsLow, 34);
        checkOutput("fast_rises", fRises, 16);
        checkOutput("fast_period", fBadGap, 0);
        checkOutput("fast_word", fRx, 16'h9E37);
        checkOutput("fast_latency", fDoneCyc - fGrantCyc, 35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
